// File: rtl/timestamp_serializer_if.sv
// -----------------------------------------------------------------------------
// timestamp_serializer_if
//   Bundles the request side (send/timestamp/busy) and the serial TX side
//   (tx_data/new_tx_data/tx_busy) of the timestamp serializer.
//
//   Signals
//     send         request a frame (serializer samples it only when idle)
//     timestamp    unsigned millisecond count, TS_BITS wide
//     busy         serializer owns a frame in flight
//     tx_data      ASCII byte towards avr_interface
//     new_tx_data  one-cycle strobe qualifying tx_data
//     tx_busy      avr_interface TX busy, high = do not strobe
//
//   Modports
//     master  the side that requests frames and hosts the TX port
//     slave   the serializer itself
// -----------------------------------------------------------------------------
interface timestamp_serializer_if #(
    parameter int TS_BITS = 24
);
    logic               send;
    logic [TS_BITS-1:0] timestamp;
    logic               busy;
    logic [7:0]         tx_data;
    logic               new_tx_data;
    logic               tx_busy;

    modport master (
        output send,
        output timestamp,
        input  busy,
        input  tx_data,
        input  new_tx_data,
        output tx_busy
    );

    modport slave (
        input  send,
        input  timestamp,
        output busy,
        output tx_data,
        output new_tx_data,
        input  tx_busy
    );
endinterface

// File: rtl/timestamp_serializer.sv
// -----------------------------------------------------------------------------
// timestamp_serializer
//   Latches the board millisecond timestamp on a send request, converts it to
//   BCD with a bit-serial double-dabble (one input bit per cycle) and streams
//   the ASCII frame  <int digits> '.' <frac digits> CR LF  one byte at a time
//   into the avr_interface TX port.
//
//   Ports
//     clk     system clock
//     rst_n   asynchronous active-low reset, aborts any frame in flight
//     bus     timestamp_serializer_if.slave
//               in : send, timestamp, tx_busy
//               out: tx_data, new_tx_data, busy (all registered)
//
//   Parameters
//     TS_BITS      timestamp width
//     DIGITS       decimal digits emitted (10**DIGITS > 2**TS_BITS-1)
//     FRAC_DIGITS  digits after the '.', 0 drops the '.'
//     TERM_CRLF    1 appends CR LF, 0 appends nothing
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no frame; busy low; waits for send
//   CONVERT | TS_BITS double-dabble steps on the latched timestamp
//   SEND    | strobe the current character as soon as tx_busy is low
//   GAP     | one dead cycle so tx_busy from avr_interface can catch up
// -----------------------------------------------------------------------------
module timestamp_serializer #(
    parameter int TS_BITS     = 24,
    parameter int DIGITS      = 8,
    parameter int FRAC_DIGITS = 3,
    parameter int TERM_CRLF   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    timestamp_serializer_if.slave bus
);

    localparam int HAS_DOT    = (FRAC_DIGITS > 0) ? 1 : 0;
    localparam int INT_DIGITS = DIGITS - FRAC_DIGITS;
    localparam int FRAME_LEN  = DIGITS + HAS_DOT + 2 * TERM_CRLF;
    localparam int BCD_W      = 4 * DIGITS;
    localparam int CNT_W      = $clog2(TS_BITS + 1);
    localparam int IDX_W      = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SEND    = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TS_BITS-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   char_idx_q, char_idx_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               new_tx_q, new_tx_d;
    logic               busy_q, busy_d;

    logic               conv_last;
    logic               char_last;
    logic [BCD_W-1:0]   bcd_adj;
    logic [7:0]         char_byte;
    logic [3:0]         digit_nib;
    logic               is_digit;
    int                 char_pos;
    int                 digit_sel;

    assign conv_last = (bit_cnt_q == CNT_W'(TS_BITS - 1));
    assign char_last = (char_idx_q == IDX_W'(FRAME_LEN - 1));

    // Double-dabble correction: any nibble that would reach 10 or more after
    // the coming shift is pre-biased by 3 so the shift carries into the next
    // decade.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < DIGITS; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    // Character for the current frame position. The '.' sits between the
    // integer and fractional digits, so fractional positions are offset by
    // one when it is present. Nibble DIGITS-1 is the most significant digit.
    always_comb begin
        char_pos  = int'(char_idx_q);
        digit_sel = 0;
        is_digit  = 1'b0;
        char_byte = 8'h00;
        if (char_pos < INT_DIGITS) begin
            is_digit  = 1'b1;
            digit_sel = DIGITS - 1 - char_pos;
        end else if ((HAS_DOT == 1) && (char_pos == INT_DIGITS)) begin
            char_byte = 8'h2E;
        end else if (char_pos < DIGITS + HAS_DOT) begin
            is_digit  = 1'b1;
            digit_sel = DIGITS - 1 - (char_pos - HAS_DOT);
        end else if (char_pos == DIGITS + HAS_DOT) begin
            char_byte = 8'h0D;
        end else begin
            char_byte = 8'h0A;
        end

        digit_nib = 4'h0;
        for (int n = 0; n < DIGITS; n++) begin
            if (n == digit_sel) begin
                digit_nib = bcd_q[4*n +: 4];
            end
        end
        if (is_digit) begin
            char_byte = {4'h3, digit_nib};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            char_idx_q <= '0;
            tx_data_q  <= 8'h00;
            new_tx_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            char_idx_q <= char_idx_d;
            tx_data_q  <= tx_data_d;
            new_tx_q   <= new_tx_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.send) begin
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (conv_last) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!bus.tx_busy) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = char_last ? S_IDLE : S_SEND;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // new_tx_d defaults low, so the strobe can only ever last one cycle.
    always_comb begin
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        char_idx_d = char_idx_q;
        tx_data_d  = tx_data_q;
        new_tx_d   = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.send) begin
                    shift_d   = bus.timestamp;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            S_CONVERT: begin
                bcd_d     = {bcd_adj[BCD_W-2:0], shift_q[TS_BITS-1]};
                shift_d   = {shift_q[TS_BITS-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (conv_last) begin
                    char_idx_d = '0;
                end
            end
            S_SEND: begin
                if (!bus.tx_busy) begin
                    tx_data_d = char_byte;
                    new_tx_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (char_last) begin
                    busy_d = 1'b0;
                end else begin
                    char_idx_d = char_idx_q + IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.new_tx_data = new_tx_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_timestamp_serializer.sv
module tb_timestamp_serializer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   rand_busy = 1'b0;

    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    logic [7:0] rx6_q[$];
    logic [7:0] exp_q[$];
    int         double_strobe = 0;
    logic       prev_strobe = 1'b0;
    logic       prev_strobe6 = 1'b0;

    timestamp_serializer_if #(.TS_BITS(24)) bus ();
    timestamp_serializer_if #(.TS_BITS(24)) bus6 ();

    timestamp_serializer #(
        .TS_BITS(24), .DIGITS(8), .FRAC_DIGITS(3), .TERM_CRLF(1)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    timestamp_serializer #(
        .TS_BITS(24), .DIGITS(8), .FRAC_DIGITS(0), .TERM_CRLF(0)
    ) u_dut6 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus6.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.new_tx_data === 1'b1) begin
            rx_q.push_back(bus.tx_data);
            rx_cyc.push_back(cyc);
            if (prev_strobe) double_strobe++;
        end
        prev_strobe = (bus.new_tx_data === 1'b1);
        if (bus6.new_tx_data === 1'b1) begin
            rx6_q.push_back(bus6.tx_data);
            if (prev_strobe6) double_strobe++;
        end
        prev_strobe6 = (bus6.new_tx_data === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            if (rand_busy) bus.tx_busy = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    // Reference frame built from the decimal value with plain arithmetic.
    task automatic build_expected(input int unsigned ts, input int digits,
                                  input int frac, input bit crlf);
        longint unsigned pw;
        exp_q.delete();
        for (int p = digits - 1; p >= 0; p--) begin
            pw = 1;
            for (int k = 0; k < p; k++) pw = pw * 10;
            if (frac > 0 && p == frac - 1) exp_q.push_back(8'h2E);
            exp_q.push_back(8'h30 + 8'((longint'(ts) / pw) % 10));
        end
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic compare_frame(input string tag, input logic [7:0] q[$], input int base);
        logic [31:0] got;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < q.size()) ? {24'h0, q[base + i]} : 32'hDEAD;
            check($sformatf("%s_b%0d", tag, i), got, {24'h0, exp_q[i]});
        end
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int cnt;
        cnt = 0;
        while (rx_q.size() < n && cnt < budget) begin
            step(1);
            cnt++;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic pulse_send(input logic [23:0] ts, output int s_cyc);
        bus.timestamp = ts;
        bus.send      = 1'b1;
        step(1);
        s_cyc    = cyc;
        bus.send = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [23:0] ts);
        int s;
        clear_rx();
        pulse_send(ts, s);
        wait_rx({tag, "_wait"}, 11, 600);
        step(1);
        check({tag, "_busy_low"}, bus.busy, 0);
        build_expected(ts, 8, 3, 1'b1);
        compare_frame(tag, rx_q, 0);
    endtask

    initial begin
        int s_cyc;
        int c_rel;
        int cnt;
        logic [23:0] ts;

        rst_n = 1'b0;
        bus.send = 1'b0;  bus.timestamp = '0;  bus.tx_busy = 1'b0;
        bus6.send = 1'b0; bus6.timestamp = '0; bus6.tx_busy = 1'b0;
        step(3);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_new_tx_data", bus.new_tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst6_busy", bus6.busy, 0);
        rst_n = 1'b1;
        step(3);
        check("idle_no_strobe", rx_q.size(), 0);
        check("idle_busy", bus.busy, 0);

        // T1: basic frame, latency, spacing, busy release
        clear_rx();
        pulse_send(24'd12345678, s_cyc);
        check("t1_busy_after_send", bus.busy, 1);
        wait_rx("t1_wait11", 11, 200);
        check("t1_busy_at_last", bus.busy, 1);
        step(1);
        check("t1_busy_low", bus.busy, 0);
        build_expected(12345678, 8, 3, 1'b1);
        compare_frame("t1", rx_q, 0);
        if (rx_cyc.size() >= 11) begin
            check("t1_latency", rx_cyc[0] - s_cyc, 25);
            for (int i = 1; i < 11; i++)
                check($sformatf("t1_spacing%0d", i), rx_cyc[i] - rx_cyc[i-1], 2);
        end

        // T2: boundaries
        run_frame("t2_zero", 24'd0);
        run_frame("t2_max", 24'hFFFFFF);

        // Random timestamps with random tx_busy back-pressure
        rand_busy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ts = 24'($urandom_range(0, 32'h00FFFFFF));
            run_frame($sformatf("rnd%0d", r), ts);
        end
        rand_busy = 1'b0;
        bus.tx_busy = 1'b0;
        step(2);

        // T3: tx_busy held across byte 3
        clear_rx();
        pulse_send(24'd12345678, s_cyc);
        wait_rx("t3_wait2", 2, 100);
        bus.tx_busy = 1'b1;
        step(100);
        check("t3_hold_count", rx_q.size(), 2);
        check("t3_hold_strobe", bus.new_tx_data, 0);
        c_rel = cyc;
        bus.tx_busy = 1'b0;
        wait_rx("t3_wait3", 3, 10);
        if (rx_cyc.size() >= 3) check("t3_resume_cyc", rx_cyc[2] - c_rel, 1);
        wait_rx("t3_wait11", 11, 100);
        step(1);
        check("t3_busy_low", bus.busy, 0);
        build_expected(12345678, 8, 3, 1'b1);
        compare_frame("t3", rx_q, 0);

        // T4: send mid-frame ignored
        clear_rx();
        pulse_send(24'd12345678, s_cyc);
        wait_rx("t4_wait4", 4, 100);
        bus.timestamp = 24'd999;
        bus.send = 1'b1;
        step(1);
        bus.send = 1'b0;
        wait_rx("t4_wait11", 11, 100);
        build_expected(12345678, 8, 3, 1'b1);
        compare_frame("t4", rx_q, 0);
        step(80);
        check("t4_no_second", rx_q.size(), 11);
        check("t4_busy_low", bus.busy, 0);

        // T4b: send held high for three back-to-back frames
        clear_rx();
        ts = 24'($urandom_range(0, 32'h00FFFFFF));
        bus.timestamp = ts;
        bus.send = 1'b1;
        wait_rx("t4b_wait33", 33, 400);
        bus.send = 1'b0;
        build_expected(ts, 8, 3, 1'b1);
        compare_frame("t4b_f0", rx_q, 0);
        compare_frame("t4b_f1", rx_q, 11);
        compare_frame("t4b_f2", rx_q, 22);
        if (rx_cyc.size() >= 33) begin
            check("t4b_period01", rx_cyc[11] - rx_cyc[0], 47);
            check("t4b_period12", rx_cyc[22] - rx_cyc[11], 47);
        end
        step(60);
        check("t4b_no_fourth", rx_q.size(), 33);
        check("t4b_busy_low", bus.busy, 0);

        // T5: async reset during byte 6
        clear_rx();
        pulse_send(24'($urandom_range(0, 32'h00FFFFFF)), s_cyc);
        wait_rx("t5_wait6", 6, 100);
        check("t5_strobe_live", bus.new_tx_data, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_strobe", bus.new_tx_data, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_tx_data", bus.tx_data, 8'h00);
        step(4);
        rst_n = 1'b1;
        step(4);
        check("t5_no_partial", rx_q.size(), 6);
        check("t5_idle_busy", bus.busy, 0);
        run_frame("t5_42", 24'd42);

        // T6: no '.', no CR/LF variant
        rx6_q.delete();
        bus6.timestamp = 24'd7;
        bus6.send = 1'b1;
        step(1);
        bus6.send = 1'b0;
        cnt = 0;
        while (rx6_q.size() < 8 && cnt < 100) begin
            step(1);
            cnt++;
        end
        check("t6_wait8", rx6_q.size(), 8);
        build_expected(7, 8, 0, 1'b0);
        compare_frame("t6", rx6_q, 0);
        step(30);
        check("t6_len", rx6_q.size(), 8);
        check("t6_busy_low", bus6.busy, 0);

        check("no_double_strobe", double_strobe, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
